// File: rtl/pmu_seq_mc.sv
// rtl/pmu_seq_mc.sv - multi-channel PMU sequencer: per-iteration drive/settle/sample scan, period pacing, close
// Adds abort, a done-handshake watchdog and sticky error status.
module pmu_seq_mc #(
   parameter int CH_NUM          = 8,
   parameter int CH_IDX_DW       = 3,
   parameter int PMU_TIME_DW     = 15,
   parameter int PMU_SMP_WAIT_DW = 16,
   parameter int PMU_TEST_NUM_DW = 16,
   parameter int PMU_CLOSE_T_DW  = 20,
   parameter int TICK_DIV        = 100,
   parameter int WDOG_DW         = 24
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [CH_NUM-1:0]          cfg_pmu_ch_en,
   input  logic [PMU_TEST_NUM_DW-1:0] cfg_pmu_test_num,
   input  logic [PMU_TIME_DW-1:0]     cfg_pmu_time,
   input  logic [PMU_SMP_WAIT_DW-1:0] cfg_pmu_smp_wait_time,
   input  logic [PMU_CLOSE_T_DW-1:0]  cfg_pmu_close_time,
   input  logic [WDOG_DW-1:0]         cfg_wdog_limit,
   input  logic                       pmu_work_start,
   input  logic                       pmu_abort,
   input  logic                       adc_ready,
   input  logic                       pmu_drv_done,
   input  logic                       pmu_smp_done,
   output logic                       pmu_busy,
   output logic                       pmu_drv_start,
   output logic                       pmu_smp_start,
   output logic [CH_IDX_DW-1:0]       pmu_cur_ch,
   output logic                       pmu_close,
   output logic                       pmu_work_done,
   output logic [PMU_TEST_NUM_DW-1:0] pmu_iter_cnt,
   output logic [2:0]                 pmu_err
);
   localparam int TD_W  = $clog2(TICK_DIV + 1);
   localparam int CL_W  = PMU_CLOSE_T_DW + TD_W;
   localparam int SW_W  = PMU_SMP_WAIT_DW + TD_W;
   localparam int M_W   = (CL_W > SW_W) ? CL_W : SW_W;
   localparam int CNT_W = ((M_W > WDOG_DW) ? M_W : WDOG_DW) + 1;
   localparam int PER_W = PMU_TIME_DW + TD_W + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_DRV, S_DRV_WAIT, S_SETTLE, S_SMP_REQ, S_SMP_WAIT,
      S_PERIOD, S_CLOSE, S_CLOSE_WAIT, S_DONE
   } state_t;

   state_t                     state, state_nx;
   logic [CH_NUM-1:0]          ch_en_q;
   logic [PMU_TEST_NUM_DW-1:0] test_num_q, test_num_eff, iter_cnt;
   logic [PMU_TIME_DW-1:0]     time_q;
   logic [PMU_SMP_WAIT_DW-1:0] smp_wait_q;
   logic [PMU_CLOSE_T_DW-1:0]  close_t_q;
   logic [WDOG_DW-1:0]         wdog_q;
   logic [CNT_W-1:0]           st_cnt, settle_lim, close_lim;
   logic [PER_W-1:0]           per_cnt, per_lim;
   logic [CH_IDX_DW-1:0]       cur_ch, ch_nx, first_ch, nxt_ch;
   logic [CH_NUM-1:0]          scan_mask;
   logic [2:0]                 err;
   logic has_nxt, start_ok, start_rej, abort_ok, wdog_trip, iter_inc, wd_hit, per_hit;

   // st_cnt holds the 1-based cycle index within the current state, so a limit of L
   // cycles measured from the event that caused the entry is reached at st_cnt == L-1.
   function automatic logic lim_hit(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] lim);
      return (lim == '0) || (cnt >= lim - CNT_W'(1));
   endfunction

   assign settle_lim   = CNT_W'(smp_wait_q) * CNT_W'(TICK_DIV);
   assign close_lim    = CNT_W'(close_t_q) * CNT_W'(TICK_DIV);
   assign per_lim      = PER_W'(time_q) * PER_W'(TICK_DIV);
   assign per_hit      = (per_lim == '0) || (per_cnt >= per_lim - PER_W'(1));
   assign wd_hit       = (wdog_q != '0) && (st_cnt >= CNT_W'(wdog_q));
   assign test_num_eff = (test_num_q == '0) ? PMU_TEST_NUM_DW'(1) : test_num_q;
   assign scan_mask    = (state == S_IDLE) ? cfg_pmu_ch_en : ch_en_q;
   assign abort_ok     = pmu_abort && !(state inside {S_IDLE, S_CLOSE, S_CLOSE_WAIT, S_DONE});

   always_comb begin
      first_ch = '0;
      nxt_ch   = '0;
      has_nxt  = 1'b0;
      for (int i = CH_NUM - 1; i >= 0; i--) begin
         if (scan_mask[i]) first_ch = CH_IDX_DW'(i);
         if (ch_en_q[i] && (CH_IDX_DW'(i) > cur_ch)) begin
            nxt_ch  = CH_IDX_DW'(i);
            has_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ch_nx     = cur_ch;
      start_ok  = 1'b0;
      start_rej = 1'b0;
      wdog_trip = 1'b0;
      iter_inc  = 1'b0;
      case (state)
         S_IDLE: if (pmu_work_start) begin
            if (|cfg_pmu_ch_en) begin
               start_ok = 1'b1;
               ch_nx    = first_ch;
               state_nx = S_DRV;
            end else begin
               start_rej = 1'b1;
            end
         end
         S_DRV:      state_nx = S_DRV_WAIT;
         S_DRV_WAIT: if (pmu_drv_done) state_nx = S_SETTLE;
                     else if (wd_hit) begin wdog_trip = 1'b1; state_nx = S_CLOSE; end
         S_SETTLE:   if (lim_hit(st_cnt, settle_lim)) state_nx = S_SMP_REQ;
         S_SMP_REQ:  if (adc_ready) state_nx = S_SMP_WAIT;
         S_SMP_WAIT: if (pmu_smp_done) begin
            if (has_nxt) begin
               ch_nx    = nxt_ch;
               state_nx = S_DRV;
            end else begin
               iter_inc = 1'b1;
               state_nx = S_PERIOD;
            end
         end else if (wd_hit) begin
            wdog_trip = 1'b1;
            state_nx  = S_CLOSE;
         end
         S_PERIOD: if (per_hit) begin
            if (iter_cnt == test_num_eff) state_nx = S_CLOSE;
            else begin
               ch_nx    = first_ch;
               state_nx = S_DRV;
            end
         end
         S_CLOSE:      state_nx = S_CLOSE_WAIT;
         S_CLOSE_WAIT: if (lim_hit(st_cnt, close_lim)) state_nx = S_DONE;
         S_DONE:       state_nx = S_IDLE;
         default:      state_nx = S_IDLE;
      endcase
      // Abort overrides any done/watchdog decision taken in the same cycle.
      if (abort_ok) begin
         state_nx  = S_CLOSE;
         ch_nx     = cur_ch;
         iter_inc  = 1'b0;
         wdog_trip = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cur_ch     <= '0;
         st_cnt     <= '0;
         per_cnt    <= '0;
         iter_cnt   <= '0;
         err        <= '0;
         ch_en_q    <= '0;
         test_num_q <= '0;
         time_q     <= '0;
         smp_wait_q <= '0;
         close_t_q  <= '0;
         wdog_q     <= '0;
      end else begin
         state  <= state_nx;
         cur_ch <= ch_nx;
         if (state_nx != state) st_cnt <= CNT_W'(1);
         else if (st_cnt != '1) st_cnt <= st_cnt + CNT_W'(1);
         // Period timer restarts on the first drive of every iteration.
         if (state_nx == S_DRV && (state == S_IDLE || state == S_PERIOD)) per_cnt <= '0;
         else if (per_cnt != '1) per_cnt <= per_cnt + PER_W'(1);
         if (start_ok) begin
            iter_cnt   <= '0;
            err        <= '0;
            ch_en_q    <= cfg_pmu_ch_en;
            test_num_q <= cfg_pmu_test_num;
            time_q     <= cfg_pmu_time;
            smp_wait_q <= cfg_pmu_smp_wait_time;
            close_t_q  <= cfg_pmu_close_time;
            wdog_q     <= cfg_wdog_limit;
         end else begin
            if (iter_inc && iter_cnt != '1) iter_cnt <= iter_cnt + PMU_TEST_NUM_DW'(1);
            err <= err | {start_rej, abort_ok, wdog_trip};
         end
      end
   end

   assign pmu_busy      = (state != S_IDLE);
   assign pmu_drv_start = (state == S_DRV);
   assign pmu_smp_start = (state == S_SMP_REQ) && adc_ready && !pmu_abort;
   assign pmu_close     = (state == S_CLOSE);
   assign pmu_work_done = (state == S_DONE);
   assign pmu_cur_ch    = cur_ch;
   assign pmu_iter_cnt  = iter_cnt;
   assign pmu_err       = err;
endmodule
